// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the data-memory responder.
package data_mem_responder_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  // Number of word-index bits for a RAM of the given depth
  function automatic int unsigned idx_width(input int unsigned depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane alignment: load extraction/extension, store shifting and byte enables.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic        is_write,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic [3:0]  byte_en,
  output logic        misalign,
  output logic        illegal
);

  logic [15:0] shifted;

  // Decode access size, extension and faults from funct3 and the byte lane
  always_comb begin
    shifted    = 16'(rd_word >> {lane, 3'b000});
    store_word = wdata << {lane, 3'b000};
    load_data  = '0;
    byte_en    = '0;
    misalign   = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        load_data = {{24{shifted[7]}}, shifted[7:0]};
        byte_en   = 4'b0001 << lane;
      end
      F3_H: begin
        load_data = {{16{shifted[15]}}, shifted};
        byte_en   = 4'b0011 << lane;
        misalign  = lane[0];
      end
      F3_W: begin
        load_data = rd_word;
        byte_en   = 4'b1111;
        misalign  = (lane != 2'b00);
      end
      F3_BU: begin
        load_data = {24'h0, shifted[7:0]};
        illegal   = is_write;
      end
      F3_HU: begin
        load_data = {16'h0, shifted};
        misalign  = lane[0];
        illegal   = is_write;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: fixed-latency four-phase ack in front of a word RAM.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ack,
  output logic        mem_err
);

  localparam int unsigned IdxW = idx_width(DEPTH_WORDS);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, wdata_q, rdata_q, rdata_d;
  logic [2:0]      f3_q;
  logic            wr_q, ack_q, ack_d, err_q, err_d;
  logic            latch_en, commit;

  logic [31:0]     ram [DEPTH_WORDS];
  logic [IdxW-1:0] word_idx;
  logic [31:0]     rd_word, load_data, store_word;
  logic [3:0]      byte_en;
  logic            misalign, illegal, out_of_range, fault;

  assign word_idx     = addr_q[IdxW+1:2];
  assign rd_word      = ram[word_idx];
  assign out_of_range = (addr_q[31:IdxW+2] != '0);
  assign fault        = out_of_range | misalign | illegal;

  mem_lane_align u_align (
    .rd_word    (rd_word),
    .lane       (addr_q[1:0]),
    .funct3     (f3_q),
    .is_write   (wr_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word),
    .byte_en    (byte_en),
    .misalign   (misalign),
    .illegal    (illegal)
  );

  // Next-state, counter and response logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    latch_en = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          latch_en = 1'b1;
          cnt_d    = CntLoad;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          ack_d   = 1'b1;
          err_d   = fault;
          rdata_d = (fault || wr_q) ? 32'h0 : load_data;
          commit  = wr_q && !fault;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      ACK: begin
        // Four-phase: release only once the requester has dropped both strobes
        if (!mem_read && !mem_write) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, latched request and registered response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (latch_en) begin
        addr_q  <= mem_address;
        wdata_q <= wdata;
        f3_q    <= funct3;
        wr_q    <= mem_write;  // write wins when both strobes are high
      end
    end
  end

  // Byte-lane store commit on the WAIT->ACK edge; reset forces IDLE so an aborted store never lands
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) ram[word_idx][8*b +: 8] <= store_word[8*b +: 8];
      end
    end
  end

  assign rdata   = rdata_q;
  assign mem_ack = ack_q;
  assign mem_err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder with a byte-array reference model.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int unsigned DEPTH_WORDS = 256;
  localparam int unsigned LATENCY     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        mem_ack;
  logic        mem_err;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (LATENCY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .funct3      (funct3),
    .wdata       (wdata),
    .rdata       (rdata),
    .mem_ack     (mem_ack),
    .mem_err     (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        ack_prev = 1'b0;
  logic [7:0]  ref_mem [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: byte-addressed memory, access rules applied directly
  function automatic void ref_access(input bit wr, input logic [31:0] addr, input logic [2:0] f3,
                                     input logic [31:0] wd, output logic [31:0] rd,
                                     output logic err);
    int unsigned size;
    bit          legal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || (addr >= DEPTH_WORDS * 4) || ((addr % size) != 0);
    rd    = '0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < int'(size); i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < int'(size); i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
        if (size == 1 && !f3[2]) v = {{24{v[7]}}, v[7:0]};
        if (size == 2 && !f3[2]) v = {{16{v[15]}}, v[15:0]};
        rd = v;
      end
    end
  endfunction

  // Full four-phase transaction; expectation queued at issue time
  task automatic access(input bit rq, input bit wq, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input bit use_exp, input logic [31:0] exp_rd,
                        input logic exp_err);
    exp_t        e;
    logic [31:0] mrd;
    logic        merr;
    int          n;
    ref_access(wq, addr, f3, wd, mrd, merr);
    e.rd  = use_exp ? exp_rd : mrd;
    e.err = use_exp ? exp_err : merr;
    @(negedge clk);
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    mem_read    = rq;
    mem_write   = wq;
    mem_address = addr;
    funct3      = f3;
    wdata       = wd;
    @(negedge clk);
    // Request fields are latched; scrambling them now must not matter
    mem_address = $urandom;
    wdata       = $urandom;
    funct3      = 3'($urandom_range(0, 7));
    n = 0;
    while (!mem_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_ack) begin
      $display("FAIL ack_timeout: got no ack expected ack within 20 cycles");
      $fatal(1, "ack timeout");
    end
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      check("ack_held", 32'(mem_ack), 32'd1);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("ack_drop", 32'(mem_ack), 32'd0);
  endtask

  // Monitor: compare each ack rise against the oldest expectation
  always @(negedge clk) begin
    if (reset) begin
      ack_prev <= 1'b0;
    end else begin
      if (mem_ack && !ack_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack expected none");
        end else begin
          mon_e = exp_q.pop_front();
          check("rdata", rdata, mon_e.rd);
          check("mem_err", 32'(mem_err), 32'(mon_e.err));
          check("latency", 32'(cyc - mon_e.cyc), 32'(LATENCY));
        end
      end
      ack_prev <= mem_ack;
    end
  end

  initial begin
    exp_t        e;
    logic [31:0] mrd;
    logic        merr;
    logic [31:0] a;
    int          n;
    bit          wq, rq;

    repeat (2) @(negedge clk);
    check("reset_ack", 32'(mem_ack), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_err", 32'(mem_err), 32'd0);
    reset = 1'b0;

    // Give the first 16 words known contents
    for (int i = 0; i < 16; i++)
      access(1'b0, 1'b1, 32'(4 * i), F3_W, (i == 8) ? 32'h0BADF00D : $urandom, 1'b0, '0, 1'b0);

    access(1'b0, 1'b1, 32'h10, F3_W, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h10, F3_W, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 32'h13, F3_B, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0);
    access(1'b1, 1'b0, 32'h13, F3_BU, 32'h0, 1'b1, 32'h000000DE, 1'b0);
    access(1'b1, 1'b0, 32'h12, F3_H, 32'h0, 1'b1, 32'hFFFFDEAD, 1'b0);
    access(1'b1, 1'b0, 32'h12, F3_HU, 32'h0, 1'b1, 32'h0000DEAD, 1'b0);
    access(1'b1, 1'b0, 32'h10, F3_B, 32'h0, 1'b1, 32'hFFFFFFEF, 1'b0);
    access(1'b0, 1'b1, 32'h12, F3_H, 32'hFFFF1234, 1'b1, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h10, F3_W, 32'h0, 1'b1, 32'h1234BEEF, 1'b0);
    access(1'b0, 1'b1, 32'h11, F3_B, 32'h000000AA, 1'b1, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h10, F3_W, 32'h0, 1'b1, 32'h1234AAEF, 1'b0);
    access(1'b1, 1'b0, 32'h11, F3_H, 32'h0, 1'b1, 32'h0, 1'b1);
    access(1'b0, 1'b1, 32'h12, F3_W, 32'h0, 1'b1, 32'h0, 1'b1);
    access(1'b1, 1'b0, 32'h10, F3_W, 32'h0, 1'b1, 32'h1234AAEF, 1'b0);
    access(1'b1, 1'b0, 32'h10, 3'b011, 32'h0, 1'b1, 32'h0, 1'b1);
    access(1'b1, 1'b0, 32'h400, F3_W, 32'h0, 1'b1, 32'h0, 1'b1);
    // Out-of-range store aliases word 0 in the index bits; it must not land there
    access(1'b0, 1'b1, 32'h400, F3_W, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1);
    access(1'b1, 1'b0, 32'h0, F3_W, 32'h0, 1'b0, '0, 1'b0);
    // Both strobes high is a write
    access(1'b1, 1'b1, 32'h14, F3_W, 32'h600DCAFE, 1'b1, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h14, F3_W, 32'h0, 1'b1, 32'h600DCAFE, 1'b0);

    // Reset while in WAIT aborts the store
    @(negedge clk);
    mem_write   = 1'b1;
    mem_address = 32'h20;
    funct3      = F3_W;
    wdata       = 32'h55AA55AA;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ack_reset_wait", 32'(mem_ack), 32'd0);
    end
    mem_write = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check("ack_after_reset", 32'(mem_ack), 32'd0);
    access(1'b1, 1'b0, 32'h20, F3_W, 32'h0, 1'b1, 32'h0BADF00D, 1'b0);

    // Reset while in ACK drops the ack without waiting for a clock edge
    ref_access(1'b1, 32'h24, F3_W, 32'h13579BDF, mrd, merr);
    @(negedge clk);
    e.rd  = mrd;
    e.err = merr;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    mem_write   = 1'b1;
    mem_address = 32'h24;
    funct3      = F3_W;
    wdata       = 32'h13579BDF;
    n = 0;
    while (!mem_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ack_before_async_reset", 32'(mem_ack), 32'd1);
    #1 reset = 1'b1;
    #1 check("ack_async_drop", 32'(mem_ack), 32'd0);
    mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    access(1'b1, 1'b0, 32'h24, F3_W, 32'h0, 1'b1, 32'h13579BDF, 1'b0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 80; i++) begin
      wq = 1'($urandom_range(0, 1));
      rq = !wq || ($urandom_range(0, 7) == 0);
      a  = ($urandom_range(0, 9) == 0) ? (32'h400 | $urandom) : 32'($urandom_range(0, 63));
      access(rq, wq, a, 3'($urandom_range(0, 7)), $urandom, 1'b0, '0, 1'b0);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
